// File: rtl/psr_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// psr_cond_unit_pkg
// Shared definitions for the PSR / condition-resolution unit:
//   - flag vector and condition-code widths
//   - bit positions of each flag inside the PSR
//   - the 4-bit condition-code enumeration
//   - the result-holding FSM state type
// -----------------------------------------------------------------------------
package psr_cond_unit_pkg;

    localparam int PSR_W  = 5;
    localparam int COND_W = 4;

    // Flag positions inside the PSR vector
    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_HI = 4'd4,
        COND_LS = 4'd5,
        COND_GT = 4'd6,
        COND_LE = 4'd7,
        COND_FS = 4'd8,
        COND_FC = 4'd9,
        COND_LO = 4'd10,
        COND_HS = 4'd11,
        COND_LT = 4'd12,
        COND_GE = 4'd13,
        COND_UC = 4'd14,
        COND_NV = 4'd15
    } cond_code_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// psr_cond_unit_cond_eval
// Purely combinational condition resolver: (flags, cond_code) -> taken.
// Ports:
//   flags     in  PSR_W   flag vector to test ([0]C [1]F [2]L [3]Z [4]N)
//   cond_code in  COND_W  condition to evaluate
//   taken     out 1       1 when the condition holds
// The reserved code NV always resolves to not-taken.
// -----------------------------------------------------------------------------
module psr_cond_unit_cond_eval
    import psr_cond_unit_pkg::*;
(
    input  logic [PSR_W-1:0]  flags,
    input  logic [COND_W-1:0] cond_code,
    output logic              taken
);

    logic c_s;
    logic f_s;
    logic l_s;
    logic z_s;
    logic n_s;

    assign c_s = flags[PSR_C];
    assign f_s = flags[PSR_F];
    assign l_s = flags[PSR_L];
    assign z_s = flags[PSR_Z];
    assign n_s = flags[PSR_N];

    // Decode the condition code against the individual flags
    always_comb begin
        taken = 1'b0;
        case (cond_code_e'(cond_code))
            COND_EQ: taken = z_s;
            COND_NE: taken = ~z_s;
            COND_CS: taken = c_s;
            COND_CC: taken = ~c_s;
            COND_HI: taken = l_s;
            COND_LS: taken = ~l_s;
            COND_GT: taken = n_s;
            COND_LE: taken = ~n_s;
            COND_FS: taken = f_s;
            COND_FC: taken = ~f_s;
            COND_LO: taken = ~l_s & ~z_s;
            COND_HS: taken = l_s | z_s;
            COND_LT: taken = ~n_s & ~z_s;
            COND_GE: taken = n_s | z_s;
            COND_UC: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_cond_unit.sv
// -----------------------------------------------------------------------------
// psr_cond_unit
// Holds the architectural PSR fed by the ALU and resolves branch/jump
// conditions against it, returning a registered taken/not-taken result over
// a valid/ready handshake (1-cycle latency, full back-to-back throughput).
//
// Ports:
//   clk          in  1       system clock, rising edge
//   reset_n      in  1       asynchronous active-low reset
//   psr_in       in  PSR_W   flag vector from ALU
//   psr_we       in  PSR_W   per-flag write mask
//   cond_valid   in  1       condition request valid
//   cond_code    in  COND_W  condition to evaluate
//   cond_ready   out 1       request can be accepted this cycle
//   res_valid    out 1       result available
//   res_taken    out 1       condition true
//   res_ready    in  1       consumer accepts result
//   flush        in  1       discard held result / drop request
//   psr_save     in  1       copy PSR to shadow (PSR_CTX_SAVE_EN only)
//   psr_restore  in  1       copy shadow to PSR (PSR_CTX_SAVE_EN only)
//   psr_q        out PSR_W   current architectural PSR
//
// Build option: define PSR_CTX_SAVE_EN to add one shadow PSR register with
// save/restore (both together swap). Without it the two controls are ignored.
// -----------------------------------------------------------------------------
module psr_cond_unit
    import psr_cond_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PSR_W-1:0]  psr_in,
    input  logic [PSR_W-1:0]  psr_we,
    input  logic              cond_valid,
    input  logic [COND_W-1:0] cond_code,
    output logic              cond_ready,
    output logic              res_valid,
    output logic              res_taken,
    input  logic              res_ready,
    input  logic              flush,
    input  logic              psr_save,
    input  logic              psr_restore,
    output logic [PSR_W-1:0]  psr_q
);

    state_e             state_r;
    state_e             next_state_s;
    logic [PSR_W-1:0]   psr_r;
    logic [PSR_W-1:0]   psr_next_s;
    logic [PSR_W-1:0]   psr_masked_s;
    logic               taken_r;
    logic               taken_next_s;
    logic               eval_taken_s;
    logic               cond_ready_s;
    logic               accept_s;

    assign psr_masked_s = (psr_r & ~psr_we) | (psr_in & psr_we);

`ifdef PSR_CTX_SAVE_EN
    logic [PSR_W-1:0]   shadow_r;
    logic [PSR_W-1:0]   shadow_next_s;

    // Next PSR: a restore overrides any same-cycle flag write
    always_comb begin
        psr_next_s = psr_masked_s;
        if (psr_restore) begin
            psr_next_s = shadow_r;
        end else begin
            psr_next_s = psr_masked_s;
        end
    end

    // Next shadow: save captures the pre-write PSR, so save+restore swaps
    always_comb begin
        shadow_next_s = shadow_r;
        if (psr_save) begin
            shadow_next_s = psr_r;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Shadow PSR register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r <= {PSR_W{1'b0}};
        end else begin
            shadow_r <= shadow_next_s;
        end
    end
`else
    logic unused_ctx_s;
    assign unused_ctx_s = psr_save ^ psr_restore;

    // Next PSR: plain per-flag masked write
    always_comb begin
        psr_next_s = psr_masked_s;
    end
`endif

    // Requests evaluate against the next PSR so same-cycle writes forward
    psr_cond_unit_cond_eval u_cond_eval (
        .flags     (psr_next_s),
        .cond_code (cond_code),
        .taken     (eval_taken_s)
    );

    // A request can enter when no result is held or the held one leaves now
    assign cond_ready_s = ~flush & ((state_r == ST_IDLE) | res_ready);
    assign accept_s     = cond_valid & cond_ready_s;

    // Result FSM: next state and next held result
    always_comb begin
        next_state_s = state_r;
        taken_next_s = taken_r;
        if (flush) begin
            next_state_s = ST_IDLE;
            taken_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        next_state_s = ST_HOLD;
                        taken_next_s = eval_taken_s;
                    end else begin
                        next_state_s = ST_IDLE;
                        taken_next_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        if (accept_s) begin
                            next_state_s = ST_HOLD;
                            taken_next_s = eval_taken_s;
                        end else begin
                            next_state_s = ST_IDLE;
                            taken_next_s = 1'b0;
                        end
                    end else begin
                        next_state_s = ST_HOLD;
                        taken_next_s = taken_r;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    taken_next_s = 1'b0;
                end
            endcase
        end
    end

    // State, PSR and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            psr_r   <= {PSR_W{1'b0}};
            taken_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            psr_r   <= psr_next_s;
            taken_r <= taken_next_s;
        end
    end

    assign cond_ready = cond_ready_s;
    assign res_valid  = (state_r == ST_HOLD);
    assign res_taken  = taken_r;
    assign psr_q      = psr_r;

endmodule
